// File: rtl/tick_divider_multi.sv
// rtl/tick_divider_multi.sv - multi-channel programmable tick/square-wave divider
module tick_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = 100000,
  parameter int CH_W        = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] clk_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] pending_div;
    logic             pending_vld;
    logic             tick_r;
    logic             sq_r;
    logic             hit;
    logic             running;
    logic             wrap;

    // Selects at or above NUM_CH never match any generated channel index.
    assign hit     = wr_en && (wr_ch == CH_W'(i));
    assign running = en[i] && (active_div != '0);
    assign wrap    = (cnt == active_div - CNT_W'(1));

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt         <= '0;
        active_div  <= CNT_W'(DEFAULT_DIV);
        pending_div <= CNT_W'(DEFAULT_DIV);
        pending_vld <= 1'b0;
        tick_r      <= 1'b0;
        sq_r        <= 1'b0;
      end else if (sync_clr) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
        if (hit) begin
          active_div  <= wr_div;
          pending_vld <= 1'b0;
        end else if (pending_vld) begin
          active_div  <= pending_div;
          pending_vld <= 1'b0;
        end
      end else if (!running) begin
        // Idle channels take a new divisor immediately and restart from zero.
        tick_r <= 1'b0;
        if (hit) begin
          active_div  <= wr_div;
          cnt         <= '0;
          pending_vld <= 1'b0;
        end
      end else begin
        if (wrap) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          sq_r   <= ~sq_r;
          if (pending_vld) begin
            active_div  <= pending_div;
            pending_vld <= 1'b0;
          end
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_r <= 1'b0;
        end
        // A write on the wrap edge is held for the following wrap.
        if (hit) begin
          pending_div <= wr_div;
          pending_vld <= 1'b1;
        end
      end
    end

    assign tick_out[i] = tick_r;
    assign clk_out[i]  = sq_r;
  end

endmodule
